// File: rtl/mshr_miss_ctrl_pkg.sv
// Shared widths and types for the MSHR miss controller slice.
// ADDR_WIDTH      : miss line address width
// TRANS_ID_WIDTH  : width of the allocation transaction-id counter
// mshr_state_e    : miss-handling FSM states
package mshr_miss_ctrl_pkg;

  localparam int unsigned ADDR_WIDTH     = 32;
  localparam int unsigned TRANS_ID_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    ISSUE  = 2'd2
  } mshr_state_e;

endpackage

// File: rtl/mshr_miss_ctrl_arb.sv
// Round-robin arbiter: one-hot grant among req, search starts at the index
// after the last advanced grant (index 0 out of reset).
// Ports: clk, rst_n, req[NUM_REQ], advance (commit current grant),
//        grant[NUM_REQ] (combinational one-hot), grant_idx (binary of grant).
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [PW-1:0]      grant_idx
);

  logic [PW-1:0] ptr_q;
  logic          found;
  int unsigned   k;

  // Rotating priority search starting at ptr_q
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    k         = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = (32'(ptr_q) + i) % NUM_REQ;
      if (!found && req[PW'(k)]) begin
        grant[PW'(k)] = 1'b1;
        grant_idx     = PW'(k);
        found         = 1'b1;
      end
    end
  end

  // Pointer moves past the committed winner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (advance && found) begin
      ptr_q <= (grant_idx == PW'(NUM_REQ - 1)) ? '0 : PW'(grant_idx + 1'b1);
    end
  end

endmodule

// File: rtl/mshr_miss_ctrl.sv
// MSHR miss controller: arbitrates miss requesters, looks each miss up in
// the MSHR, merges into a pending entry or allocates a new one and issues
// the memory request; memory responses release all waiters of an entry.
// Ports: req_* (requester side), mshr_lookup_*/mshr_alloc_*/mshr_dealloc_*
//        (MSHR storage side), mem_req_*/mem_rsp_* (memory side),
//        cpl_* (completion broadcast to released requesters).
module mshr_miss_ctrl
  import mshr_miss_ctrl_pkg::*;
#(
  parameter  int unsigned NUM_REQ      = 4,
  parameter  int unsigned MSHR_ENTRIES = 8,
  localparam int unsigned IW           = $clog2(MSHR_ENTRIES)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr,
  output logic [NUM_REQ-1:0]                   req_ready,
  output logic [ADDR_WIDTH-1:0]                mshr_lookup_addr,
  input  logic                                 mshr_lookup_hit,
  input  logic [IW-1:0]                        mshr_lookup_entry,
  output logic                                 mshr_allocate,
  output logic [ADDR_WIDTH-1:0]                mshr_alloc_addr,
  output logic [TRANS_ID_WIDTH-1:0]            mshr_alloc_trans_id,
  input  logic                                 mshr_alloc_ready,
  input  logic [IW-1:0]                        mshr_alloc_entry,
  output logic                                 mshr_deallocate,
  output logic [IW-1:0]                        mshr_dealloc_entry,
  output logic                                 mem_req_valid,
  input  logic                                 mem_req_ready,
  output logic [ADDR_WIDTH-1:0]                mem_req_addr,
  output logic [IW-1:0]                        mem_req_id,
  input  logic                                 mem_rsp_valid,
  input  logic [IW-1:0]                        mem_rsp_id,
  output logic                                 mem_rsp_ready,
  output logic                                 cpl_valid,
  output logic [NUM_REQ-1:0]                   cpl_mask,
  output logic [ADDR_WIDTH-1:0]                cpl_addr
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  mshr_state_e               state_q, state_d;
  logic [NUM_REQ-1:0]        arb_grant;
  logic [PW-1:0]             arb_idx;
  logic                      arb_advance;
  logic                      do_merge;
  logic [ADDR_WIDTH-1:0]     lat_addr_q;
  logic [NUM_REQ-1:0]        lat_req_q;
  logic [TRANS_ID_WIDTH-1:0] trans_id_q;
  logic [ADDR_WIDTH-1:0]     issue_addr_q;
  logic [IW-1:0]             issue_entry_q;
  logic [ADDR_WIDTH-1:0]     ent_addr_q [MSHR_ENTRIES];
  logic [NUM_REQ-1:0]        ent_wait_q [MSHR_ENTRIES];
  logic [NUM_REQ-1:0]        rsp_merge;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .advance   (arb_advance),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  assign mshr_lookup_addr    = lat_addr_q;
  assign mshr_alloc_addr     = lat_addr_q;
  assign mshr_alloc_trans_id = trans_id_q;
  assign mem_req_valid       = (state_q == ISSUE);
  assign mem_req_addr        = issue_addr_q;
  assign mem_req_id          = issue_entry_q;
  assign mem_rsp_ready       = 1'b1;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake strobes
  always_comb begin
    state_d       = state_q;
    req_ready     = '0;
    arb_advance   = 1'b0;
    mshr_allocate = 1'b0;
    do_merge      = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready   = arb_grant;
          arb_advance = 1'b1;
          state_d     = LOOKUP;
        end
      end
      LOOKUP: begin
        if (mshr_lookup_hit) begin
          do_merge = 1'b1;
          state_d  = IDLE;
        end else if (mshr_alloc_ready) begin
          mshr_allocate = 1'b1;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_req_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture, transaction id and issue payload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_addr_q    <= '0;
      lat_req_q     <= '0;
      trans_id_q    <= '0;
      issue_addr_q  <= '0;
      issue_entry_q <= '0;
    end else begin
      if (arb_advance) begin
        lat_addr_q <= req_addr[arb_idx];
        lat_req_q  <= arb_grant;
      end
      if (mshr_allocate) begin
        trans_id_q    <= TRANS_ID_WIDTH'(trans_id_q + 1'b1);
        issue_addr_q  <= lat_addr_q;
        issue_entry_q <= mshr_alloc_entry;
      end
    end
  end

  // Per-entry waiters: merge, then response clear, then fresh allocation win
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned e = 0; e < MSHR_ENTRIES; e++) begin
        ent_addr_q[e] <= '0;
        ent_wait_q[e] <= '0;
      end
    end else begin
      for (int unsigned e = 0; e < MSHR_ENTRIES; e++) begin
        if (do_merge && mshr_lookup_entry == IW'(e))
          ent_wait_q[e] <= ent_wait_q[e] | lat_req_q;
        if (mem_rsp_valid && mem_rsp_id == IW'(e))
          ent_wait_q[e] <= '0;
        if (mshr_allocate && mshr_alloc_entry == IW'(e)) begin
          ent_wait_q[e] <= lat_req_q;
          ent_addr_q[e] <= lat_addr_q;
        end
      end
    end
  end

  // A merge landing on the responding entry joins this completion directly
  assign rsp_merge = (do_merge && mshr_lookup_entry == mem_rsp_id) ? lat_req_q : '0;

  // Completion / deallocation pulses, one cycle after the response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mshr_deallocate    <= 1'b0;
      mshr_dealloc_entry <= '0;
      cpl_valid          <= 1'b0;
      cpl_mask           <= '0;
      cpl_addr           <= '0;
    end else begin
      mshr_deallocate    <= mem_rsp_valid;
      cpl_valid          <= mem_rsp_valid;
      mshr_dealloc_entry <= mem_rsp_valid ? mem_rsp_id : '0;
      cpl_mask           <= mem_rsp_valid ? (ent_wait_q[mem_rsp_id] | rsp_merge) : '0;
      cpl_addr           <= mem_rsp_valid ? ent_addr_q[mem_rsp_id] : '0;
    end
  end

endmodule

// File: tb/tb_mshr_miss_ctrl.sv
// Bench for mshr_miss_ctrl: plays the MSHR storage and memory, keeps a
// transaction-level model of entries/waiters, round-robin order and ids.
module tb_mshr_miss_ctrl;
  import mshr_miss_ctrl_pkg::*;

  localparam int NR = 4;
  localparam int NE = 8;
  localparam int IW = 3;
  localparam int AW = ADDR_WIDTH;
  localparam int TW = TRANS_ID_WIDTH;

  logic                   clk, rst_n;
  logic [NR-1:0]          req_valid, req_ready;
  logic [NR-1:0][AW-1:0]  req_addr;
  logic [AW-1:0]          mshr_lookup_addr, mshr_alloc_addr, mem_req_addr, cpl_addr;
  logic                   mshr_lookup_hit, mshr_allocate, mshr_alloc_ready, mshr_deallocate;
  logic [IW-1:0]          mshr_lookup_entry, mshr_alloc_entry, mshr_dealloc_entry, mem_req_id, mem_rsp_id;
  logic [TW-1:0]          mshr_alloc_trans_id;
  logic                   mem_req_valid, mem_req_ready, mem_rsp_valid, mem_rsp_ready, cpl_valid;
  logic [NR-1:0]          cpl_mask;

  mshr_miss_ctrl #(.NUM_REQ(NR), .MSHR_ENTRIES(NE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .mshr_lookup_addr(mshr_lookup_addr), .mshr_lookup_hit(mshr_lookup_hit),
    .mshr_lookup_entry(mshr_lookup_entry),
    .mshr_allocate(mshr_allocate), .mshr_alloc_addr(mshr_alloc_addr),
    .mshr_alloc_trans_id(mshr_alloc_trans_id), .mshr_alloc_ready(mshr_alloc_ready),
    .mshr_alloc_entry(mshr_alloc_entry),
    .mshr_deallocate(mshr_deallocate), .mshr_dealloc_entry(mshr_dealloc_entry),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_id(mem_req_id),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_id(mem_rsp_id), .mem_rsp_ready(mem_rsp_ready),
    .cpl_valid(cpl_valid), .cpl_mask(cpl_mask), .cpl_addr(cpl_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [NR-1:0] m_wait [NE];
  logic [AW-1:0] m_addr [NE];
  bit            m_valid[NE];
  int            m_ptr, m_tid;
  bit            e_cpl;
  int            e_id;
  logic [NR-1:0] e_mask;
  logic [AW-1:0] e_addr;
  // What the bench is doing in the current cycle
  bit            c_merge, c_alloc, c_rsp;
  int            c_merge_e, c_alloc_e, c_rsp_id;
  logic [NR-1:0] c_bit;
  logic [AW-1:0] c_line;
  int            rsp_prob;

  typedef struct { logic [NR-1:0] valid; logic [NR-1:0] exp_grant; } arb_vec_t;
  arb_vec_t tbl[12];

  function automatic int rr_pick(input int ptr, input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[(ptr + i) % NR]) return (ptr + i) % NR;
    return -1;
  endfunction

  function automatic int pick_free();
    int c[$];
    for (int e = 0; e < NE; e++) if (!m_valid[e]) c.push_back(e);
    if (c.size() == 0) return -1;
    return c[$urandom_range(0, c.size() - 1)];
  endfunction

  function automatic int pick_valid();
    int c[$];
    for (int e = 0; e < NE; e++) if (m_valid[e]) c.push_back(e);
    if (c.size() == 0) return -1;
    return c[$urandom_range(0, c.size() - 1)];
  endfunction

  function automatic int find_hit(input logic [AW-1:0] a);
    for (int e = 0; e < NE; e++) if (m_valid[e] && m_addr[e] == a) return e;
    return -1;
  endfunction

  task automatic clear_cycle();
    c_merge = 0; c_alloc = 0; c_rsp = 0;
  endtask

  task automatic model_reset();
    for (int e = 0; e < NE; e++) begin m_wait[e] = '0; m_addr[e] = '0; m_valid[e] = 0; end
    m_ptr = 0; m_tid = 0; e_cpl = 0;
    clear_cycle();
  endtask

  task automatic rand_rsp();
    int v;
    if (rsp_prob > 0 && $urandom_range(0, 99) < rsp_prob) begin
      v = pick_valid();
      if (v >= 0) begin c_rsp = 1; c_rsp_id = v; end
    end
  endtask

  // First half: drive response, reach negedge, check completion expectation
  task automatic half1();
    mem_rsp_valid = c_rsp;
    mem_rsp_id    = IW'(c_rsp_id);
    @(negedge clk);
    chk("cpl_valid", cpl_valid, e_cpl);
    chk("dealloc", mshr_deallocate, e_cpl);
    if (e_cpl) begin
      chk("dealloc_entry", mshr_dealloc_entry, e_id);
      chk("cpl_mask", cpl_mask, e_mask);
      chk("cpl_addr", cpl_addr, e_addr);
    end
  endtask

  // Second half: advance the model across the clock edge
  task automatic half2();
    e_cpl = c_rsp;
    if (c_rsp) begin
      e_id   = c_rsp_id;
      e_mask = m_wait[c_rsp_id] | ((c_merge && c_merge_e == c_rsp_id) ? c_bit : '0);
      e_addr = m_addr[c_rsp_id];
    end
    if (c_merge) m_wait[c_merge_e] = m_wait[c_merge_e] | c_bit;
    if (c_rsp) begin m_wait[c_rsp_id] = '0; m_valid[c_rsp_id] = 0; end
    if (c_alloc) begin
      m_wait[c_alloc_e] = c_bit; m_addr[c_alloc_e] = c_line; m_valid[c_alloc_e] = 1;
      m_tid = (m_tid + 1) % (1 << TW);
    end
    clear_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_allocate", mshr_allocate, 0);
    chk("rst_dealloc", mshr_deallocate, 0);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_cpl_valid", cpl_valid, 0);
    chk("rst_cpl_mask", cpl_mask, 0);
    chk("rst_lookup_addr", mshr_lookup_addr, 0);
    chk("rst_alloc_addr", mshr_alloc_addr, 0);
    chk("rst_trans_id", mshr_alloc_trans_id, 0);
    chk("rst_dealloc_entry", mshr_dealloc_entry, 0);
    chk("rst_mem_req_addr", mem_req_addr, 0);
    chk("rst_mem_req_id", mem_req_id, 0);
    chk("rst_cpl_addr", cpl_addr, 0);
    chk("rst_mem_rsp_ready", mem_rsp_ready, 1);
  endtask

  task automatic drive_idle();
    req_valid = '0; mshr_lookup_hit = 0; mshr_lookup_entry = '0;
    mshr_alloc_ready = 0; mshr_alloc_entry = '0; mem_req_ready = 0;
    mem_rsp_valid = 0; mem_rsp_id = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    drive_idle();
    model_reset();
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic quiet_cycle();
    drive_idle();
    rand_rsp();
    half1();
    chk("idle_mem_req_valid", mem_req_valid, 0);
    chk("idle_allocate", mshr_allocate, 0);
    half2();
  endtask

  task automatic rsp_cycle(input int id);
    drive_idle();
    c_rsp = 1; c_rsp_id = id;
    half1();
    half2();
  endtask

  // One request through grant, lookup (merge or allocate with stalls), issue
  task automatic txn(input logic [NR-1:0] vmask, input int stall, input int mem_wait,
                     input int alloc_e, input int rsp_e, input bit rst_issue);
    int g, he, ae, s;
    logic [NR-1:0] gbit;
    logic [AW-1:0] line;
    g    = rr_pick(m_ptr, vmask);
    gbit = NR'(1) << g;
    line = req_addr[g];
    // grant cycle
    drive_idle();
    req_valid = vmask;
    rand_rsp();
    half1();
    chk("req_ready", req_ready, gbit);
    chk("grant_no_alloc", mshr_allocate, 0);
    half2();
    m_ptr = (g + 1) % NR;
    // lookup
    req_valid = NR'($urandom);
    he = find_hit(line);
    if (he >= 0) begin
      mshr_lookup_hit = 1; mshr_lookup_entry = IW'(he);
      c_merge = 1; c_merge_e = he; c_bit = gbit;
      if (rsp_e >= 0) begin c_rsp = 1; c_rsp_id = rsp_e; end else rand_rsp();
      half1();
      chk("lookup_addr", mshr_lookup_addr, line);
      chk("hit_no_alloc", mshr_allocate, 0);
      chk("hit_no_grant", req_ready, 0);
      half2();
      mshr_lookup_hit = 0;
      return;
    end
    s = 0;
    while (s < stall || pick_free() < 0) begin
      req_valid = NR'($urandom);
      mshr_alloc_ready = 0;
      if (pick_free() < 0) begin c_rsp = 1; c_rsp_id = pick_valid(); end else rand_rsp();
      half1();
      chk("stall_no_alloc", mshr_allocate, 0);
      chk("stall_no_grant", req_ready, 0);
      chk("stall_lookup_addr", mshr_lookup_addr, line);
      half2();
      s++;
    end
    ae = (alloc_e >= 0) ? alloc_e : pick_free();
    mshr_alloc_ready = 1; mshr_alloc_entry = IW'(ae);
    c_alloc = 1; c_alloc_e = ae; c_bit = gbit; c_line = line;
    if (rsp_e >= 0) begin c_rsp = 1; c_rsp_id = rsp_e; end else rand_rsp();
    half1();
    chk("allocate", mshr_allocate, 1);
    chk("alloc_addr", mshr_alloc_addr, line);
    chk("alloc_trans_id", mshr_alloc_trans_id, m_tid);
    chk("alloc_no_grant", req_ready, 0);
    half2();
    mshr_alloc_ready = 0;
    // issue
    for (int w = 0; w <= mem_wait; w++) begin
      req_valid = NR'($urandom);
      mem_req_ready = (w == mem_wait);
      rand_rsp();
      half1();
      chk("mem_req_valid", mem_req_valid, 1);
      chk("mem_req_addr", mem_req_addr, line);
      chk("mem_req_id", mem_req_id, ae);
      chk("issue_no_grant", req_ready, 0);
      if (rst_issue) begin
        #2;
        rst_n = 0;
        drive_idle();
        #1;
        check_reset_outputs();
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        return;
      end
      half2();
    end
    mem_req_ready = 0;
  endtask

  initial begin
    rsp_prob = 0;
    rst_n = 0;
    drive_idle();
    req_addr = '0;
    tbl[0]  = '{4'b1111, 4'b0001}; tbl[1]  = '{4'b1111, 4'b0010};
    tbl[2]  = '{4'b1111, 4'b0100}; tbl[3]  = '{4'b1111, 4'b1000};
    tbl[4]  = '{4'b1111, 4'b0001}; tbl[5]  = '{4'b0100, 4'b0100};
    tbl[6]  = '{4'b1010, 4'b1000}; tbl[7]  = '{4'b0110, 4'b0010};
    tbl[8]  = '{4'b0001, 4'b0001}; tbl[9]  = '{4'b1001, 4'b1000};
    tbl[10] = '{4'b1000, 4'b1000}; tbl[11] = '{4'b0011, 4'b0001};
    do_reset();

    // Arbitration table: every grant merges into entry 0 so the FSM returns to IDLE
    for (int r = 0; r < NR; r++) req_addr[r] = AW'(32'h100 * (r + 1));
    for (int i = 0; i < 12; i++) begin
      logic [AW-1:0] ea;
      ea = '0;
      for (int r = 0; r < NR; r++) if (tbl[i].exp_grant[r]) ea = req_addr[r];
      drive_idle();
      req_valid = tbl[i].valid;
      half1();
      chk("tbl_grant", req_ready, tbl[i].exp_grant);
      half2();
      req_valid = '0;
      mshr_lookup_hit = 1; mshr_lookup_entry = '0;
      c_merge = 1; c_merge_e = 0; c_bit = tbl[i].exp_grant;
      half1();
      chk("tbl_lookup_addr", mshr_lookup_addr, ea);
      chk("tbl_no_alloc", mshr_allocate, 0);
      half2();
    end

    // Directed corner cases
    do_reset();
    req_addr = '0;
    req_addr[1] = 32'h1000;
    txn(4'b0010, 0, 1, 3, -1, 0);                  // single miss, entry 3, id 0
    req_addr[2] = 32'h1000;
    txn(4'b0100, 0, 0, -1, -1, 0);                 // merge into entry 3
    rsp_cycle(3);
    drive_idle();
    half1();
    chk("merge_cpl_mask", cpl_mask, 4'b0110);
    chk("merge_dealloc_entry", mshr_dealloc_entry, 3);
    half2();
    req_addr[3] = 32'h2000;
    txn(4'b1000, 5, 0, 4, -1, 0);                  // five stall cycles
    req_addr[0] = 32'h5000;
    txn(4'b0001, 0, 0, 5, -1, 0);
    req_addr[1] = 32'h5000;
    txn(4'b0010, 0, 0, -1, 5, 0);                  // merge and response to entry 5 together
    drive_idle();
    half1();
    chk("same_cycle_cpl_mask", cpl_mask, 4'b0011);
    half2();
    req_addr[2] = 32'h6000;
    txn(4'b0100, 0, 0, 6, 4, 0);                   // allocate 6 while 4 responds
    rsp_cycle(6);
    rsp_cycle(7);                                  // spurious, back-to-back
    drive_idle();
    half1();
    chk("spurious_cpl_valid", cpl_valid, 1);
    chk("spurious_cpl_mask", cpl_mask, 0);
    half2();
    req_addr[3] = 32'h7000;
    txn(4'b1000, 0, 3, 2, -1, 1);                  // reset while waiting on mem_req_ready
    for (int i = 0; i < 4; i++) quiet_cycle();

    // Randomized traffic against the model
    do_reset();
    rsp_prob = 30;
    for (int t = 0; t < 300; t++) begin
      logic [NR-1:0] vm;
      vm = NR'($urandom_range(1, (1 << NR) - 1));
      for (int r = 0; r < NR; r++) req_addr[r] = AW'(32'h1000 * $urandom_range(1, 6));
      txn(vm, $urandom_range(0, 2), $urandom_range(0, 2), -1, -1, 0);
      if ($urandom_range(0, 3) == 0) quiet_cycle();
    end
    rsp_prob = 0;
    quiet_cycle();
    quiet_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
